// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush producer: load-use bubbles, dmem wait freezes and branch flushes
// for the 5-stage core. It also keeps a stall-cycle statistic and a memory-wait watchdog.
module hazard_stall_ctrl #(
  parameter int WAIT_LIMIT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             in_mem_wait,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WCW = $clog2(WAIT_LIMIT + 2);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(WAIT_LIMIT + 1);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu_s;
  logic mw_s;
  logic stall_pc_s, stall_ifid_s, stall_idex_s, stall_exmem_s;
  logic flush_ifid_s, flush_idex_s;

  // Hazard detection terms; writes to x0 never create a dependency
  always_comb begin
    mw_s = mem_req & ~mem_ready;
    lu_s = ex_is_load & (ex_rd != 5'd0) &
           ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  // Stall/flush controls: state-independent priority, so a release cycle out of the
  // wait state evaluates branch and load-use exactly as the run state does
  always_comb begin
    stall_pc_s    = 1'b0;
    stall_ifid_s  = 1'b0;
    stall_idex_s  = 1'b0;
    stall_exmem_s = 1'b0;
    flush_ifid_s  = 1'b0;
    flush_idex_s  = 1'b0;
    if (!reset) begin
      stall_pc_s    = 1'b0;
      flush_ifid_s  = 1'b0;
    end else if (mw_s) begin
      stall_pc_s    = 1'b1;
      stall_ifid_s  = 1'b1;
      stall_idex_s  = 1'b1;
      stall_exmem_s = 1'b1;
    end else if (ex_branch_taken) begin
      flush_ifid_s  = 1'b1;
      flush_idex_s  = 1'b1;
    end else if (lu_s) begin
      stall_pc_s    = 1'b1;
      stall_ifid_s  = 1'b1;
      flush_idex_s  = 1'b1;
    end else begin
      stall_pc_s    = 1'b0;
      flush_ifid_s  = 1'b0;
    end
  end

  // Next state, wait-counter, watchdog and statistics update
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mw_s) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (mw_s) begin
          state_d = ST_MEM_WAIT;
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
    mem_timeout_d = mem_timeout_q | (wait_cnt_d == WAIT_MAX);
    if (stall_pc_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State register; reset aborts any wait in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign stall_pc     = stall_pc_s;
  assign stall_ifid   = stall_ifid_s;
  assign stall_idex   = stall_idex_s;
  assign stall_exmem  = stall_exmem_s;
  assign flush_ifid   = flush_ifid_s;
  assign flush_idex   = flush_idex_s;
  assign in_mem_wait  = (state_q == ST_MEM_WAIT);
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares against the live outputs.
module tb_hazard_stall_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken, mem_req, mem_ready;
  logic          stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic          flush_ifid, flush_idex, in_mem_wait, mem_timeout;
  logic [CW-1:0] stall_cycles;

  typedef struct packed {
    logic [3:0]    st;
    logic [1:0]    fl;
    logic          imw;
    logic          tmo;
    logic [CW-1:0] sc;
  } exp_t;

  typedef struct {
    int   idx;
    exp_t e;
  } sb_t;

  sb_t  sb_q[$];
  int   checks;
  int   errors;
  int   vec_idx;

  hazard_stall_ctrl #(.WAIT_LIMIT(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .in_mem_wait(in_mem_wait), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue its expectation
  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic ld, input logic br, input logic req, input logic rdy,
                      input logic [3:0] st, input logic [1:0] fl, input logic imw,
                      input logic tmo, input logic [CW-1:0] sc);
    sb_t item;
    @(posedge clk);
    #1;
    reset = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_is_load = ld; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
    item.idx = vec_idx;
    item.e   = '{st: st, fl: fl, imw: imw, tmo: tmo, sc: sc};
    sb_q.push_back(item);
    vec_idx++;
  endtask

  task automatic idle(input logic r, input logic imw, input logic tmo, input logic [CW-1:0] sc);
    step(r, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, imw, tmo, sc);
  endtask

  task automatic memw(input logic rdy, input logic [3:0] st, input logic imw,
                      input logic tmo, input logic [CW-1:0] sc);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, rdy, st, 2'b00, imw, tmo, sc);
  endtask

  // Monitor: compare the oldest expectation against the outputs mid-cycle
  always @(negedge clk) begin
    sb_t  item;
    exp_t act;
    if (sb_q.size() > 0) begin
      item = sb_q.pop_front();
      act  = '{st: {stall_pc, stall_ifid, stall_idex, stall_exmem},
               fl: {flush_ifid, flush_idex}, imw: in_mem_wait, tmo: mem_timeout,
               sc: stall_cycles};
      checks++;
      if (act !== item.e) begin
        errors++;
        $display("FAIL vec%0d: got st=%b fl=%b imw=%b tmo=%b sc=%0d, want st=%b fl=%b imw=%b tmo=%b sc=%0d",
                 item.idx, act.st, act.fl, act.imw, act.tmo, act.sc,
                 item.e.st, item.e.fl, item.e.imw, item.e.tmo, item.e.sc);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; vec_idx = 0;
    reset = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

    // reset, load-use, x0 exclusion, use-flag gating, branch beats load-use
    idle(1'b0, 1'b0, 1'b0, 4'd0);
    idle(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 2'b01, 1'b0, 1'b0, 4'd0);
    idle(1'b1, 1'b0, 1'b0, 4'd1);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 4'd1);
    step(1'b1, 5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 4'd1);
    step(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 2'b01, 1'b0, 1'b0, 4'd1);
    idle(1'b1, 1'b0, 1'b0, 4'd2);
    step(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'b11, 1'b0, 1'b0, 4'd2);

    // zero-wait access, then a three-cycle wait
    memw(1'b1, 4'b0000, 1'b0, 1'b0, 4'd2);
    memw(1'b0, 4'b1111, 1'b0, 1'b0, 4'd2);
    memw(1'b0, 4'b1111, 1'b1, 1'b0, 4'd3);
    memw(1'b0, 4'b1111, 1'b1, 1'b0, 4'd4);
    memw(1'b1, 4'b0000, 1'b1, 1'b0, 4'd5);
    idle(1'b0, 1'b0, 1'b0, 4'd0);
    idle(1'b1, 1'b0, 1'b0, 4'd0);

    // branch held across a wait is flushed only at release
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 2'b00, 1'b0, 1'b0, 4'd0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 2'b00, 1'b1, 1'b0, 4'd1);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 2'b11, 1'b1, 1'b0, 4'd2);
    idle(1'b1, 1'b0, 1'b0, 4'd2);

    // load-use held across a wait that ends by mem_req dropping
    step(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 2'b00, 1'b0, 1'b0, 4'd2);
    step(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 2'b01, 1'b1, 1'b0, 4'd3);
    idle(1'b1, 1'b0, 1'b0, 4'd4);

    // watchdog: six wait cycles with WAIT_LIMIT=4, timeout sticky after release
    memw(1'b0, 4'b1111, 1'b0, 1'b0, 4'd4);
    memw(1'b0, 4'b1111, 1'b1, 1'b0, 4'd5);
    memw(1'b0, 4'b1111, 1'b1, 1'b0, 4'd6);
    memw(1'b0, 4'b1111, 1'b1, 1'b0, 4'd7);
    memw(1'b0, 4'b1111, 1'b1, 1'b0, 4'd8);
    memw(1'b0, 4'b1111, 1'b1, 1'b1, 4'd9);
    memw(1'b1, 4'b0000, 1'b1, 1'b1, 4'd10);
    idle(1'b1, 1'b0, 1'b1, 4'd10);

    // stall counter saturates at 15
    memw(1'b0, 4'b1111, 1'b0, 1'b1, 4'd10);
    for (int i = 11; i <= 15; i++) memw(1'b0, 4'b1111, 1'b1, 1'b1, CW'(i));
    memw(1'b0, 4'b1111, 1'b1, 1'b1, 4'd15);
    memw(1'b1, 4'b0000, 1'b1, 1'b1, 4'd15);
    idle(1'b1, 1'b0, 1'b1, 4'd15);

    // asynchronous reset in the middle of a wait
    memw(1'b0, 4'b1111, 1'b0, 1'b1, 4'd15);
    memw(1'b0, 4'b1111, 1'b1, 1'b1, 4'd15);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 4'd0);
    idle(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 2'b01, 1'b0, 1'b0, 4'd0);
    idle(1'b1, 1'b0, 1'b0, 4'd1);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
